// File: rtl/mips_cpu_bus_pkg.sv
// Shared constants for the multicycle MIPS bus master: opcodes, funct codes, FSM states.
// No logic of its own; combinational helper only.
// Not applicable (no handshake in a package).
package mips_cpu_bus_pkg;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC00000;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // SPECIAL funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALTED
    } state_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mips_cpu_bus_regfile.sv
// 32x32 GPR file: two async read ports, one sync write port, live $2 tap.
// Reads are combinational; writes land on the next rising edge.
// No backpressure; $0 reads as zero and ignores writes.
module mips_cpu_bus_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_addr,
    output logic [31:0] rs_data,
    input  logic [4:0]  rt_addr,
    output logic [31:0] rt_data,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic [31:0] v0
);

    logic [31:0] regs [0:31];

    // Register array update; $0 is never written so it stays at its reset value of zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != 5'd0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    assign rs_data = (rs_addr == 5'd0) ? 32'd0 : regs[rs_addr];
    assign rt_data = (rt_addr == 5'd0) ? 32'd0 : regs[rt_addr];
    assign v0      = regs[2];

endmodule

// File: rtl/mips_cpu_bus.sv
// Multicycle MIPS-I subset core with a single Avalon-style memory master port.
// Latency: 2 cycles per ALU/branch op, 3 per store, 4 per load, plus slave stall cycles.
// Backpressure: waitrequest freezes state and every bus output until the slave completes.
module mips_cpu_bus
    import mips_cpu_bus_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        active,
    output logic [31:0] register_v0,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    state_t      state, state_nxt;
    // pc is the instruction being executed, npc the one fetched after it; a taken
    // branch only redirects npc, which is what gives the single delay slot.
    logic [31:0] pc, npc, ir;
    logic [31:0] mem_addr, store_data, mdr;
    logic [4:0]  load_dest;
    logic        mem_load, mem_store;

    // Instruction fields
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] simm, zimm, pc_plus4, btarget, jtarget, ea;
    logic [31:0] rs_val, rt_val;

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign shamt    = ir[10:6];
    assign funct    = ir[5:0];
    assign imm      = ir[15:0];
    assign simm     = sext16(imm);
    assign zimm     = {16'd0, imm};
    assign pc_plus4 = pc + 32'd4;
    assign btarget  = pc_plus4 + {simm[29:0], 2'b00};
    assign jtarget  = {pc_plus4[31:28], ir[25:0], 2'b00};
    assign ea       = rs_val + simm;

    // Execute-stage decode results
    logic        ex_we, ex_load, ex_store, ex_jump;
    logic [4:0]  ex_wa;
    logic [31:0] ex_wd, ex_target;

    // Register file write port, shared between EXEC results and load writeback
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    mips_cpu_bus_regfile u_regfile (
        .clk     (clk),
        .reset   (reset),
        .rs_addr (rs),
        .rs_data (rs_val),
        .rt_addr (rt),
        .rt_data (rt_val),
        .wr_en   (rf_we),
        .wr_addr (rf_wa),
        .wr_data (rf_wd),
        .v0      (register_v0)
    );

    // Decode and ALU for the instruction held in ir; unknown encodings fall through as NOP
    always_comb begin
        ex_we     = 1'b0;
        ex_wa     = rd;
        ex_wd     = 32'd0;
        ex_load   = 1'b0;
        ex_store  = 1'b0;
        ex_jump   = 1'b0;
        ex_target = 32'd0;
        case (opcode)
            OP_SPECIAL: begin
                ex_we = 1'b1;
                case (funct)
                    FN_ADDU: ex_wd = rs_val + rt_val;
                    FN_SUBU: ex_wd = rs_val - rt_val;
                    FN_AND:  ex_wd = rs_val & rt_val;
                    FN_OR:   ex_wd = rs_val | rt_val;
                    FN_XOR:  ex_wd = rs_val ^ rt_val;
                    FN_SLT:  ex_wd = {31'd0, ($signed(rs_val) < $signed(rt_val))};
                    FN_SLTU: ex_wd = {31'd0, (rs_val < rt_val)};
                    FN_SLL:  ex_wd = rt_val << shamt;
                    FN_SRL:  ex_wd = rt_val >> shamt;
                    FN_SRA:  ex_wd = $signed(rt_val) >>> shamt;
                    FN_JR: begin
                        ex_we     = 1'b0;
                        ex_jump   = 1'b1;
                        ex_target = rs_val;
                    end
                    default: ex_we = 1'b0;
                endcase
            end
            OP_J: begin
                ex_jump   = 1'b1;
                ex_target = jtarget;
            end
            OP_JAL: begin
                ex_jump   = 1'b1;
                ex_target = jtarget;
                ex_we     = 1'b1;
                ex_wa     = 5'd31;
                ex_wd     = pc + 32'd8;
            end
            OP_BEQ: begin
                ex_jump   = (rs_val == rt_val);
                ex_target = btarget;
            end
            OP_BNE: begin
                ex_jump   = (rs_val != rt_val);
                ex_target = btarget;
            end
            OP_ADDIU: begin ex_we = 1'b1; ex_wa = rt; ex_wd = rs_val + simm; end
            OP_SLTI:  begin ex_we = 1'b1; ex_wa = rt; ex_wd = {31'd0, ($signed(rs_val) < $signed(simm))}; end
            OP_SLTIU: begin ex_we = 1'b1; ex_wa = rt; ex_wd = {31'd0, (rs_val < simm)}; end
            OP_ANDI:  begin ex_we = 1'b1; ex_wa = rt; ex_wd = rs_val & zimm; end
            OP_ORI:   begin ex_we = 1'b1; ex_wa = rt; ex_wd = rs_val | zimm; end
            OP_XORI:  begin ex_we = 1'b1; ex_wa = rt; ex_wd = rs_val ^ zimm; end
            OP_LUI:   begin ex_we = 1'b1; ex_wa = rt; ex_wd = {imm, 16'd0}; end
            OP_LW:    ex_load  = 1'b1;
            OP_SW:    ex_store = 1'b1;
            default:  ;
        endcase
    end

    // Select the register file write source: EXEC result or loaded word in WB
    always_comb begin
        rf_we = 1'b0;
        rf_wa = ex_wa;
        rf_wd = ex_wd;
        if (state == ST_WB) begin
            rf_we = 1'b1;
            rf_wa = load_dest;
            rf_wd = mdr;
        end else if (state == ST_EXEC) begin
            rf_we = ex_we;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state; a next fetch address of zero halts instead of fetching
    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH: if (!waitrequest) state_nxt = ST_EXEC;
            ST_EXEC: begin
                if (ex_load || ex_store)  state_nxt = ST_MEM;
                else if (npc == 32'd0)    state_nxt = ST_HALTED;
                else                      state_nxt = ST_FETCH;
            end
            ST_MEM: begin
                if (!waitrequest) begin
                    if (mem_load)            state_nxt = ST_WB;
                    else if (pc == 32'd0)    state_nxt = ST_HALTED;
                    else                     state_nxt = ST_FETCH;
                end
            end
            ST_WB:     state_nxt = (pc == 32'd0) ? ST_HALTED : ST_FETCH;
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_FETCH;
        endcase
    end

    // Bus outputs; strobes are gated by reset so they drop the instant reset asserts
    always_comb begin
        active     = (state != ST_HALTED);
        read       = reset && ((state == ST_FETCH) || ((state == ST_MEM) && mem_load));
        write      = reset && (state == ST_MEM) && mem_store;
        address    = (state == ST_FETCH) ? pc : mem_addr;
        writedata  = store_data;
        byteenable = 4'b1111;
    end

    // Datapath registers: instruction capture, PC sequencing, memory operation setup
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc         <= RESET_VECTOR;
            npc        <= RESET_VECTOR + 32'd4;
            ir         <= 32'd0;
            mem_addr   <= 32'd0;
            store_data <= 32'd0;
            mdr        <= 32'd0;
            load_dest  <= 5'd0;
            mem_load   <= 1'b0;
            mem_store  <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (!waitrequest) ir <= readdata;
                end
                ST_EXEC: begin
                    pc        <= npc;
                    npc       <= ex_jump ? ex_target : (npc + 32'd4);
                    mem_load  <= ex_load;
                    mem_store <= ex_store;
                    if (ex_load || ex_store) begin
                        mem_addr  <= ea & ~32'd3;
                        load_dest <= rt;
                    end
                    if (ex_store) store_data <= rt_val;
                end
                ST_MEM: begin
                    if (!waitrequest && mem_load) mdr <= readdata;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_cpu_bus.sv
// Directed bench for mips_cpu_bus with an inline RAM model and programmable waitrequest.
module tb_mips_cpu_bus;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        active, write, read, waitrequest;
    logic [31:0] register_v0, address, writedata, readdata;
    logic [3:0]  byteenable;

    always #5 clk = ~clk;

    mips_cpu_bus #(.RESET_VECTOR(32'hBFC00000)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .active      (active),
        .register_v0 (register_v0),
        .address     (address),
        .write       (write),
        .read        (read),
        .waitrequest (waitrequest),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata)
    );

    // RAM model: 16-bit byte address space, word organised
    logic [31:0] mem [0:16383];
    int          stall_cycles = 0;
    int          cnt = 0;

    assign waitrequest = (read || write) && (cnt < stall_cycles);
    assign readdata    = mem[address[15:2]];

    always @(posedge clk) begin
        if (write && !waitrequest) begin
            for (int b = 0; b < 4; b++) begin
                if (byteenable[b]) mem[address[15:2]][8*b +: 8] = writedata[8*b +: 8];
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && (read || write)) cnt <= waitrequest ? cnt + 1 : 0;
        else                          cnt <= 0;
    end

    // Bus monitor sampled on the falling edge
    int          stable_err = 0, both_err = 0, zero_acc = 0, w_stall = 0, r_stall = 0;
    logic [31:0] last_waddr = 32'd0, last_wdata = 32'd0;
    logic [31:0] flog [$];
    logic        prev_stall = 1'b0, p_rd = 1'b0, p_wr = 1'b0;
    logic [31:0] p_addr = 32'd0, p_wd = 32'd0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (read && write) both_err++;
            if ((read || write) && address == 32'd0) zero_acc++;
            if (prev_stall && (address !== p_addr || read !== p_rd || write !== p_wr || writedata !== p_wd))
                stable_err++;
            if (write && waitrequest) w_stall++;
            if (read && waitrequest && address == 32'hBFC00100) r_stall++;
            if (write && !waitrequest) begin
                last_waddr = address;
                last_wdata = writedata;
            end
            if (read && !waitrequest) flog.push_back(address);
            prev_stall = (read || write) && waitrequest;
            p_addr = address; p_rd = read; p_wr = write; p_wd = writedata;
        end else begin
            prev_stall = 1'b0;
        end
    end

    int n_cmp = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Hand assembler helpers
    function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction
    function automatic logic [31:0] er(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                       input logic [4:0] sh, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction
    function automatic logic [31:0] ej(input logic [5:0] op, input logic [25:0] t);
        return {op, t};
    endfunction

    localparam logic [31:0] NOP = 32'h00000000;
    localparam logic [31:0] JR0 = 32'h00000008;

    task automatic clear_mem();
        for (int i = 0; i < 16384; i++) mem[i] = 32'd0;
    endtask

    // Reset, release, run until halt, then confirm the core stays halted and idle
    task automatic run(input string name);
        int k;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check({name, "_rst_read"}, {31'd0, read}, 32'd0);
        check({name, "_rst_write"}, {31'd0, write}, 32'd0);
        check({name, "_rst_wdata"}, writedata, 32'd0);
        check({name, "_rst_be"}, {28'd0, byteenable}, 32'h0000000F);
        check({name, "_rst_v0"}, register_v0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check({name, "_first_read"}, {31'd0, read}, 32'd1);
        check({name, "_first_addr"}, address, 32'hBFC00000);
        check({name, "_active"}, {31'd0, active}, 32'd1);
        k = 0;
        while (active && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check({name, "_halted"}, {31'd0, active}, 32'd0);
        repeat (4) @(negedge clk);
        check({name, "_idle"}, {30'd0, read, write}, 32'd0);
        check({name, "_still_halted"}, {31'd0, active}, 32'd0);
    endtask

    initial begin
        int fs, ws, rs0;
        logic [31:0] exp_f [0:6];

        // ADDIU $2,$0,5 ; JR $0 ; NOP
        clear_mem();
        mem[0] = ei(6'h09, 5'd0, 5'd2, 16'd5);
        mem[1] = JR0;
        mem[2] = NOP;
        run("addiu");
        check("addiu_v0", register_v0, 32'h00000005);
        check("addiu_no_zero_access", zero_acc, 32'd0);

        // LUI/ORI constant build
        clear_mem();
        mem[0] = ei(6'h0F, 5'd0, 5'd2, 16'h1234);
        mem[1] = ei(6'h0D, 5'd2, 5'd2, 16'h5678);
        mem[2] = JR0;
        mem[3] = NOP;
        run("lui_ori");
        check("lui_ori_v0", register_v0, 32'h12345678);

        // SW then LW through 3-cycle stalls on every access
        clear_mem();
        mem[0] = ei(6'h0F, 5'd0, 5'd3, 16'hDEAD);
        mem[1] = ei(6'h0D, 5'd3, 5'd3, 16'hBEEF);
        mem[2] = ei(6'h0F, 5'd0, 5'd4, 16'hBFC0);
        mem[3] = ei(6'h2B, 5'd4, 5'd3, 16'h0100);
        mem[4] = ei(6'h23, 5'd4, 5'd2, 16'h0100);
        mem[5] = JR0;
        mem[6] = NOP;
        stall_cycles = 3;
        ws = w_stall;
        rs0 = r_stall;
        run("ldst");
        stall_cycles = 0;
        check("ldst_v0", register_v0, 32'hDEADBEEF);
        check("ldst_mem", mem[64], 32'hDEADBEEF);
        check("ldst_waddr", last_waddr, 32'hBFC00100);
        check("ldst_wdata", last_wdata, 32'hDEADBEEF);
        check("ldst_wstall", w_stall - ws, 32'd3);
        check("ldst_rstall", r_stall - rs0, 32'd3);

        // BEQ taken: delay slot runs, following instruction skipped
        clear_mem();
        mem[0] = ei(6'h04, 5'd0, 5'd0, 16'd2);
        mem[1] = ei(6'h09, 5'd2, 5'd2, 16'd1);
        mem[2] = ei(6'h09, 5'd2, 5'd2, 16'd16);
        mem[3] = JR0;
        mem[4] = NOP;
        run("beq");
        check("beq_v0", register_v0, 32'h00000001);

        // JAL to 0xBFC00040, subroutine returns with JR $31, caller copies $31 to $2
        clear_mem();
        mem[0]  = ej(6'h03, 26'h3F00010);
        mem[1]  = NOP;
        mem[2]  = er(5'd31, 5'd0, 5'd2, 5'd0, 6'h21);
        mem[3]  = JR0;
        mem[4]  = NOP;
        mem[16] = er(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);
        mem[17] = NOP;
        exp_f = '{32'hBFC00000, 32'hBFC00004, 32'hBFC00040, 32'hBFC00044,
                  32'hBFC00008, 32'hBFC0000C, 32'hBFC00010};
        fs = flog.size();
        run("jal");
        check("jal_ra_in_v0", register_v0, 32'hBFC00008);
        check("jal_fetch_count", flog.size() - fs, 32'd7);
        for (int i = 0; i < 7; i++) begin
            if (fs + i < flog.size()) check($sformatf("jal_fetch%0d", i), flog[fs + i], exp_f[i]);
        end

        // ALU mix: SRA, SLT, SUBU wrap, ANDI zero-extend, write to $0 discarded
        clear_mem();
        mem[0] = ei(6'h09, 5'd0, 5'd5, 16'hFFFD);
        mem[1] = er(5'd0, 5'd5, 5'd6, 5'd1, 6'h03);
        mem[2] = er(5'd5, 5'd0, 5'd7, 5'd0, 6'h2A);
        mem[3] = er(5'd6, 5'd7, 5'd2, 5'd0, 6'h23);
        mem[4] = ei(6'h0C, 5'd5, 5'd8, 16'hFFFF);
        mem[5] = er(5'd2, 5'd8, 5'd2, 5'd0, 6'h21);
        mem[6] = ei(6'h09, 5'd0, 5'd0, 16'd7);
        mem[7] = er(5'd2, 5'd0, 5'd2, 5'd0, 6'h21);
        mem[8] = JR0;
        mem[9] = NOP;
        run("alu");
        check("alu_v0", register_v0, 32'h0000FFFA);

        // Reset asserted while a fetch is stalled
        clear_mem();
        mem[0] = ei(6'h09, 5'd0, 5'd2, 16'd5);
        mem[1] = JR0;
        mem[2] = NOP;
        stall_cycles = 100;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("stall_read", {31'd0, read}, 32'd1);
        check("stall_wait", {31'd0, waitrequest}, 32'd1);
        check("stall_addr", address, 32'hBFC00000);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_read_drop", {31'd0, read}, 32'd0);
        check("rst_mid_write", {31'd0, write}, 32'd0);
        stall_cycles = 0;
        run("restart");
        check("restart_v0", register_v0, 32'h00000005);

        // Whole-run bus protocol properties
        check("strobes_exclusive", both_err, 32'd0);
        check("stall_stability", stable_err, 32'd0);
        check("never_access_zero", zero_acc, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mips_cpu_bus.md
MIPS_CPU_BUS -- requirements
Module: mips_cpu_bus

Interface
REQ-001 Parameter RESET_VECTOR, default 32'hBFC00000, first instruction fetch address after reset.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 reset  input  1  reset is asynchronous and active-low.
REQ-004 active  output  1  high while executing; low once halted.
REQ-005 register_v0  output  32  live value of GPR $2.
REQ-006 address  output  32  byte address of the current bus transaction, word-aligned.
REQ-007 write  output  1  write strobe.
REQ-008 read  output  1  read strobe.
REQ-009 waitrequest  input  1  slave stall; high means the current transaction has not completed.
REQ-010 writedata  output  32  store data.
REQ-011 byteenable  output  4  active byte lanes; 4'b1111 for every read and write.
REQ-012 readdata  input  32  load/fetch data, valid in the cycle waitrequest is low.

Function
REQ-013 Multicycle, non-pipelined FSM: FETCH -> EXEC -> MEM (loads/stores only) -> WB (loads only) -> FETCH; plus HALTED.
REQ-014 Never assert read and write together; strobes only in FETCH (read) and MEM (read or write).
REQ-015 While waitrequest=1, hold address, read, write, writedata and byteenable stable and stay in the state.
REQ-016 Instruction and load data are captured on the first rising edge with the strobe high and waitrequest=0.
REQ-017 Supported instructions: ADDU, SUBU, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, JR, ADDIU, ANDI, ORI, XORI, SLTI, SLTIU, LUI, LW, SW, BEQ, BNE, J, JAL.
REQ-018 Arithmetic is 32-bit wrap-around, no overflow traps; ANDI/ORI/XORI zero-extend, all other immediates sign-extend.
REQ-019 Load/store effective address = rs + sign-extended imm16.
REQ-020 Writes to $0 are discarded; $0 always reads 0.
REQ-021 Branches and jumps have one architectural delay slot: the next sequential instruction always executes before the target.
REQ-022 Branch target = PC+4 + (sign-extended imm16 << 2); J/JAL target = {PC+4[31:28], imm26, 2'b00}; JAL writes PC+8 to $31.
REQ-023 Unsupported opcodes execute as NOP.
REQ-024 Halt: when the next fetch address equals 32'h00000000, enter HALTED instead of fetching; active=0, read=write=0 from then on.
REQ-025 HALTED is left only by reset; register_v0 keeps its final value.

Reset
REQ-026 While reset=0: PC=RESET_VECTOR, state=FETCH, all GPRs=0, delay-slot flag cleared, read=write=0, byteenable=4'b1111, writedata=0.
REQ-027 active=1 from reset deassertion; first bus cycle afterwards is a read at RESET_VECTOR.
REQ-028 Reset mid-transaction abandons it immediately; strobes drop asynchronously.

Structure
REQ-029 Shared package: opcode and funct constants, FSM state enum, RESET_VECTOR default.
REQ-030 One sub-module: mips_cpu_bus_regfile (32x32, two async read ports, one sync write port, $2 tap for register_v0).
REQ-031 mips_cpu_bus_tb_memory is a bench-only RAM model (16-bit byte address, byteenable writes, waitrequest generation); not part of the synthesised block.

Verification
REQ-032 ADDIU $2,$0,5; JR $0; NOP -> active falls, register_v0=32'h00000005, no access at 0.
REQ-033 LUI $2,16'h1234; ORI $2,$2,16'h5678; JR $0; NOP -> register_v0=32'h12345678.
REQ-034 SW $3 (32'hDEADBEEF) to 0xBFC00100, LW $2 same address, with waitrequest high for 3 cycles on each access -> register_v0=32'hDEADBEEF, strobe/address stable through stalls.
REQ-035 BEQ taken with ADDIU $2,$2,1 in delay slot and skipped ADDIU $2,$2,16 after it -> register_v0=32'h00000001.
REQ-036 JAL to subroutine, subroutine JR $31 -> $31=PC_jal+8, execution resumes at PC_jal+8.
REQ-037 Reset asserted during a stalled fetch -> read drops immediately; after release, fetch restarts at 32'hBFC00000 with active=1.
